// File: rtl/menu_pkg.sv
// -----------------------------------------------------------------------------
// menu_pkg
// Shared definitions for the pre-game configuration menu:
//   - state_e    : 4-bit FSM state codes (also shown on the debug display)
//   - menu_sel_e : menu item codes (modo, bpm, tom, musica)
//   - MAX_OPCOES : upper bound on the option count of any menu item
//   - helpers    : option count per item, item of a state, SEL/WR state of an item
// -----------------------------------------------------------------------------
package menu_pkg;

  localparam int MAX_OPCOES = 16;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_SEL_MODO   = 4'd1,
    ST_WR_MODO    = 4'd2,
    ST_SEL_BPM    = 4'd3,
    ST_WR_BPM     = 4'd4,
    ST_SEL_TOM    = 4'd5,
    ST_WR_TOM     = 4'd6,
    ST_SEL_MUSICA = 4'd7,
    ST_WR_MUSICA  = 4'd8,
    ST_DONE       = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    MENU_MODO   = 2'd0,
    MENU_BPM    = 2'd1,
    MENU_TOM    = 2'd2,
    MENU_MUSICA = 2'd3
  } menu_sel_e;

  // Number of options offered by a menu item.
  function automatic logic [4:0] n_opcoes(input menu_sel_e sel, input int modo,
                                          input int bpm, input int tom,
                                          input int musica);
    case (sel)
      MENU_MODO: return 5'(modo);
      MENU_BPM:  return 5'(bpm);
      MENU_TOM:  return 5'(tom);
      default:   return 5'(musica);
    endcase
  endfunction

  function automatic logic is_sel(input state_e s);
    return (s == ST_SEL_MODO) || (s == ST_SEL_BPM) ||
           (s == ST_SEL_TOM)  || (s == ST_SEL_MUSICA);
  endfunction

  function automatic logic is_wr(input state_e s);
    return (s == ST_WR_MODO) || (s == ST_WR_BPM) ||
           (s == ST_WR_TOM)  || (s == ST_WR_MUSICA);
  endfunction

  // Menu item a SEL/WR state belongs to; IDLE and DONE report MENU_MODO.
  function automatic menu_sel_e item_of(input state_e s);
    case (s)
      ST_SEL_BPM,    ST_WR_BPM:    return MENU_BPM;
      ST_SEL_TOM,    ST_WR_TOM:    return MENU_TOM;
      ST_SEL_MUSICA, ST_WR_MUSICA: return MENU_MUSICA;
      default:                     return MENU_MODO;
    endcase
  endfunction

  function automatic state_e sel_of(input menu_sel_e sel);
    case (sel)
      MENU_MODO: return ST_SEL_MODO;
      MENU_BPM:  return ST_SEL_BPM;
      MENU_TOM:  return ST_SEL_TOM;
      default:   return ST_SEL_MUSICA;
    endcase
  endfunction

  function automatic state_e wr_of(input menu_sel_e sel);
    case (sel)
      MENU_MODO: return ST_WR_MODO;
      MENU_BPM:  return ST_WR_BPM;
      MENU_TOM:  return ST_WR_TOM;
      default:   return ST_WR_MUSICA;
    endcase
  endfunction

endpackage

// File: rtl/menu_config_controller_edge_detector.sv
// -----------------------------------------------------------------------------
// edge_detector
// Rising-edge detector for one already-synchronized level input.
// pulse is high during the cycle in which din is high and was low at the
// previous rising clock edge, so a held input produces a single pulse.
// Ports:
//   clock - system clock, rising edge
//   reset - asynchronous active-low reset (clears the history flop)
//   din   - level input
//   pulse - din & ~history
// -----------------------------------------------------------------------------
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic hist_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the clock edge, independent of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) hist_q <= 1'b0;
    else        hist_q <= din;
  end

  assign pulse = din & ~hist_q;

endmodule

// File: rtl/menu_config_controller.sv
// -----------------------------------------------------------------------------
// menu_config_controller
// Sequences the pre-game configuration menu: modo -> bpm -> tom -> musica.
// Arrow presses move a wrap-around selection index, confirma writes the
// highlighted option (one-hot value plus a one-cycle register strobe) and
// advances to the next item, voltar steps back one item. After the last item
// the FSM parks in DONE with menu_pronto high until inicia_menu restarts it.
//
// Optional feature (compile-time macro MENU_TIMEOUT_EN): an inactivity counter
// returns the FSM to IDLE after CLOCK_FREQ*TIMEOUT_S cycles in a SEL_* state
// without any input pulse. Without the macro SEL_* states wait indefinitely.
//
// Ports:
//   clock, reset                 - clock (rising edge), async active-low reset
//   inicia_menu                  - start/restart level, top priority
//   right/left_arrow_pressed     - move selection (edge detected)
//   confirma, voltar             - confirm / go back (edge detected)
//   menu_sel                     - current item (0 modo, 1 bpm, 2 tom, 3 musica)
//   indice                       - highlighted option index
//   opcao_onehot                 - decode of indice while the menu is active
//   registra_modo/bpm/tom/musicas - one-cycle write strobes
//   menu_ativo, menu_pronto      - in SEL_*/WR_* states, in DONE
//   db_estado                    - state code for a debug display
// All outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
module menu_config_controller
  import menu_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int MODO       = 4,
  parameter int BPM        = 2,
  parameter int TOM        = 4,
  parameter int MUSICA     = 16,
  parameter int TIMEOUT_S  = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inicia_menu,
  input  logic        right_arrow_pressed,
  input  logic        left_arrow_pressed,
  input  logic        confirma,
  input  logic        voltar,
  output logic [1:0]  menu_sel,
  output logic [3:0]  indice,
  output logic [15:0] opcao_onehot,
  output logic        registra_modo,
  output logic        registra_bpm,
  output logic        registra_tom,
  output logic        registra_musicas,
  output logic        menu_ativo,
  output logic        menu_pronto,
  output logic [3:0]  db_estado
);

  // Elaboration-time sanity check of the configuration.
  if (MODO < 1 || MODO > MAX_OPCOES || BPM < 1 || BPM > MAX_OPCOES ||
      TOM < 1 || TOM > MAX_OPCOES || MUSICA < 1 || MUSICA > MAX_OPCOES ||
      CLOCK_FREQ < 1 || TIMEOUT_S < 1) begin : g_param_check
    $error("menu_config_controller: parameter out of range");
  end

  // ---------------------------------------------------------------------------
  // Input edge detection
  // ---------------------------------------------------------------------------
  logic dir_p, esq_p, conf_p, volta_p;

  edge_detector u_ed_dir (
    .clock (clock), .reset (reset), .din (right_arrow_pressed), .pulse (dir_p)
  );
  edge_detector u_ed_esq (
    .clock (clock), .reset (reset), .din (left_arrow_pressed), .pulse (esq_p)
  );
  edge_detector u_ed_conf (
    .clock (clock), .reset (reset), .din (confirma), .pulse (conf_p)
  );
  edge_detector u_ed_volta (
    .clock (clock), .reset (reset), .din (voltar), .pulse (volta_p)
  );

  // ---------------------------------------------------------------------------
  // State and selection index
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [3:0] indice_q, indice_d;
  menu_sel_e  item;
  logic [3:0] ultimo;       // highest legal index for the current item
  logic       timeout_hit;

  assign item   = item_of(state_q);
  assign ultimo = 4'(n_opcoes(item, MODO, BPM, TOM, MUSICA) - 5'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      indice_q <= '0;
    end else begin
      state_q  <= state_d;
      indice_q <= indice_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Inactivity timeout
  // ---------------------------------------------------------------------------
`ifdef MENU_TIMEOUT_EN
  localparam int unsigned LIMITE = CLOCK_FREQ * TIMEOUT_S;
  localparam int          CNT_W  = (LIMITE > 1) ? $clog2(LIMITE) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             any_pulse;

  assign any_pulse   = dir_p | esq_p | conf_p | volta_p;
  assign timeout_hit = is_sel(state_q) && (cnt_q == CNT_W'(LIMITE - 1));

  // Counts idle cycles spent in the current SEL_* state; any pulse (even one
  // that ends up ignored) counts as activity.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                            cnt_q <= '0;
    else if (!is_sel(state_q) || state_d != state_q || any_pulse) cnt_q <= '0;
    else                                                   cnt_q <= cnt_q + CNT_W'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    indice_d = indice_q;

    if (inicia_menu) begin
      state_d  = ST_SEL_MODO;
      indice_d = '0;
    end else if (timeout_hit) begin
      state_d  = ST_IDLE;
      indice_d = '0;
    end else if (is_sel(state_q)) begin
      // voltar in SEL_MODO has nowhere to go and is treated as absent.
      if (volta_p && item != MENU_MODO) begin
        state_d  = sel_of(menu_sel_e'(item - 2'd1));
        indice_d = '0;
      end else if (conf_p) begin
        state_d = wr_of(item);
      end else if (dir_p && !esq_p) begin
        indice_d = (indice_q == ultimo) ? 4'd0 : indice_q + 4'd1;
      end else if (esq_p && !dir_p) begin
        indice_d = (indice_q == 4'd0) ? ultimo : indice_q - 4'd1;
      end
    end else if (is_wr(state_q)) begin
      // Write states last one cycle and ignore all inputs.
      indice_d = '0;
      state_d  = (item == MENU_MUSICA) ? ST_DONE
                                       : sel_of(menu_sel_e'(item + 2'd1));
    end else if (state_q != ST_IDLE && state_q != ST_DONE) begin
      // Unused encodings recover to IDLE.
      state_d  = ST_IDLE;
      indice_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    menu_ativo       = is_sel(state_q) || is_wr(state_q);
    menu_pronto      = (state_q == ST_DONE);
    menu_sel         = menu_ativo ? item : MENU_MODO;
    indice           = indice_q;
    opcao_onehot     = menu_ativo ? (16'd1 << indice_q) : 16'd0;
    registra_modo    = (state_q == ST_WR_MODO);
    registra_bpm     = (state_q == ST_WR_BPM);
    registra_tom     = (state_q == ST_WR_TOM);
    registra_musicas = (state_q == ST_WR_MUSICA);
    db_estado        = state_q;
  end

endmodule
